// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: FSM states,
// datapath select encodings, opcode/funct constants and the instruction decoder.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WR, S_WB, S_BRANCH, S_JUMP
    } state_e;

    typedef enum logic [3:0] {
        I_ILL, I_ADD, I_SUB, I_ORI, I_LUI, I_LW, I_SW, I_BEQ,
        I_J, I_JAL, I_JR, I_MULT, I_DIV, I_MFHI, I_MFLO
    } instr_e;

    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_OR     = 3'b010;
    localparam logic [2:0] ALU_PASS_B = 3'b011;

    localparam logic [1:0] EXT_ZERO  = 2'b00;
    localparam logic [1:0] EXT_SIGN  = 2'b01;
    localparam logic [1:0] EXT_SHIFT = 2'b10;
    localparam logic [1:0] EXT_LUI   = 2'b11;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    localparam logic [1:0] RD_RT  = 2'b00;
    localparam logic [1:0] RD_RD  = 2'b01;
    localparam logic [1:0] RD_R31 = 2'b10;

    localparam logic [2:0] WB_ALU = 3'b000;
    localparam logic [2:0] WB_DM  = 3'b001;
    localparam logic [2:0] WB_PC4 = 3'b010;
    localparam logic [2:0] WB_HI  = 3'b011;
    localparam logic [2:0] WB_LO  = 3'b100;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MFLO = 6'b010010;

    function automatic instr_e decode_instr(input logic [5:0] op, input logic [5:0] func);
        instr_e r;
        r = I_ILL;
        case (op)
            OP_RTYPE: begin
                case (func)
                    FN_ADD:  r = I_ADD;
                    FN_SUB:  r = I_SUB;
                    FN_JR:   r = I_JR;
                    FN_MULT: r = I_MULT;
                    FN_DIV:  r = I_DIV;
                    FN_MFHI: r = I_MFHI;
                    FN_MFLO: r = I_MFLO;
                    default: r = I_ILL;
                endcase
            end
            OP_ORI:  r = I_ORI;
            OP_LUI:  r = I_LUI;
            OP_LW:   r = I_LW;
            OP_SW:   r = I_SW;
            OP_BEQ:  r = I_BEQ;
            OP_J:    r = I_J;
            OP_JAL:  r = I_JAL;
            default: r = I_ILL;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mc_mdu_tracker.sv
// Busy tracker for the background multiply/divide unit: a down-counter
// loaded on each start pulse with the latency of the selected operation.
module mc_mdu_tracker #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic mode_i,
    output logic busy_o
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // The start cycle is the first of the LAT busy cycles, hence LAT-1.
    always_comb begin
        cnt_d = cnt_q;
        if (start_i)
            cnt_d = mode_i ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
        else if (cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM with imem/dmem ready handshakes.
// Define MC_CTRL_MDU_EN to decode mult/div/mfhi/mflo and track the MDU.
module mc_control
    import mc_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       pc_we,
    output logic       ir_we,
    output logic [1:0] pc_src,
    output logic [2:0] alu_op,
    output logic       alu_srcb,
    output logic [1:0] ext_op,
    output logic       grf_we,
    output logic [1:0] reg_dst,
    output logic [2:0] wb_sel,
    output logic       dmem_re,
    output logic       dmem_we,
    output logic       mdu_start,
    output logic       mdu_mode,
    output logic       stall,
    output logic       illegal
);
    state_e     state_q;
    instr_e     instr_raw, instr;
    logic       mdu_op, mdu_busy;
    logic [2:0] wb_rsel;

    assign instr_raw = decode_instr(op, func);
    assign mdu_op    = instr_raw inside {I_MULT, I_DIV, I_MFHI, I_MFLO};

`ifdef MC_CTRL_MDU_EN
    assign instr     = instr_raw;
    assign stall     = (state_q == S_DECODE) && mdu_op && mdu_busy;
    assign mdu_start = (state_q == S_DECODE) && (instr inside {I_MULT, I_DIV}) && !mdu_busy;
    assign mdu_mode  = mdu_start && (instr == I_DIV);
    assign wb_rsel   = (instr == I_MFHI) ? WB_HI : (instr == I_MFLO) ? WB_LO : WB_ALU;

    mc_mdu_tracker #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_mdu (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (mdu_start),
        .mode_i  (mdu_mode),
        .busy_o  (mdu_busy)
    );
`else
    assign instr     = mdu_op ? I_ILL : instr_raw;
    assign mdu_busy  = 1'b0;
    assign stall     = 1'b0;
    assign mdu_start = 1'b0;
    assign mdu_mode  = 1'b0;
    assign wb_rsel   = WB_ALU;
`endif

    // The IR is held from DECODE onward, so later states re-read op/func.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  if (imem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    case (instr)
                        I_ADD, I_SUB:         state_q <= S_EXEC_R;
                        I_ORI, I_LUI:         state_q <= S_EXEC_I;
                        I_LW, I_SW:           state_q <= S_MEM_ADDR;
                        I_BEQ:                state_q <= S_BRANCH;
                        I_J, I_JAL, I_JR:     state_q <= S_JUMP;
                        I_MULT, I_DIV:        state_q <= mdu_busy ? S_DECODE : S_FETCH;
                        I_MFHI, I_MFLO:       state_q <= mdu_busy ? S_DECODE : S_WB;
                        default:              state_q <= S_FETCH;
                    endcase
                end
                S_EXEC_R, S_EXEC_I: state_q <= S_WB;
                S_MEM_ADDR: state_q <= (instr == I_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD, S_MEM_WR: if (dmem_ready) state_q <= S_FETCH;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        imem_req = 1'b0;
        pc_we    = 1'b0;
        ir_we    = 1'b0;
        pc_src   = PC_PLUS4;
        alu_op   = ALU_ADD;
        alu_srcb = 1'b0;
        ext_op   = EXT_ZERO;
        grf_we   = 1'b0;
        reg_dst  = RD_RT;
        wb_sel   = WB_ALU;
        dmem_re  = 1'b0;
        dmem_we  = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                pc_we    = imem_ready;
                ir_we    = imem_ready;
            end
            S_DECODE: illegal = (instr == I_ILL);
            S_EXEC_R: begin
                alu_op  = (instr == I_SUB) ? ALU_SUB : ALU_ADD;
                reg_dst = RD_RD;
            end
            S_EXEC_I: begin
                alu_srcb = 1'b1;
                alu_op   = (instr == I_LUI) ? ALU_PASS_B : ALU_OR;
                ext_op   = (instr == I_LUI) ? EXT_LUI : EXT_ZERO;
            end
            S_MEM_ADDR: begin
                alu_srcb = 1'b1;
                ext_op   = EXT_SIGN;
            end
            S_MEM_RD: begin
                dmem_re = 1'b1;
                grf_we  = dmem_ready;
                wb_sel  = WB_DM;
            end
            S_MEM_WR: dmem_we = 1'b1;
            S_WB: begin
                grf_we  = 1'b1;
                reg_dst = (instr inside {I_ADD, I_SUB, I_MFHI, I_MFLO}) ? RD_RD : RD_RT;
                wb_sel  = wb_rsel;
            end
            S_BRANCH: begin
                alu_op = ALU_SUB;
                pc_src = PC_BRANCH;
                pc_we  = zero;
            end
            S_JUMP: begin
                pc_we  = 1'b1;
                pc_src = (instr == I_JR) ? PC_RS : PC_JUMP;
                if (instr == I_JAL) begin
                    grf_we  = 1'b1;
                    reg_dst = RD_R31;
                    wb_sel  = WB_PC4;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: each step pushes the expected output
// vector for that cycle, which is popped and compared at the falling edge.
module tb_mc_control;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    localparam logic [5:0] OP_R = 6'b000000, OP_ORI = 6'b001101, OP_LUI = 6'b001111;
    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J = 6'b000010, OP_JAL = 6'b000011, OP_BAD = 6'b111111;
    localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_JR = 6'b001000;
    localparam logic [5:0] FN_MULT = 6'b011000, FN_DIV = 6'b011010;
    localparam logic [5:0] FN_MFHI = 6'b010000, FN_MFLO = 6'b010010;

    typedef struct packed {
        logic       imem_req, pc_we, ir_we;
        logic [1:0] pc_src;
        logic [2:0] alu_op;
        logic       alu_srcb;
        logic [1:0] ext_op;
        logic       grf_we;
        logic [1:0] reg_dst;
        logic [2:0] wb_sel;
        logic       dmem_re, dmem_we, mdu_start, mdu_mode, stall, illegal;
    } out_t;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic [5:0] op = '0, func = '0;
    logic       zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic       imem_req, pc_we, ir_we, alu_srcb, grf_we, dmem_re, dmem_we;
    logic       mdu_start, mdu_mode, stall, illegal;
    logic [1:0] pc_src, ext_op, reg_dst;
    logic [2:0] alu_op, wb_sel;
    out_t       obs;
    out_t       exp_q[$];
    string      tag_q[$];
    int         n_chk = 0, n_fail = 0;

    mc_control #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .func(func), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .pc_we(pc_we), .ir_we(ir_we), .pc_src(pc_src),
        .alu_op(alu_op), .alu_srcb(alu_srcb), .ext_op(ext_op), .grf_we(grf_we),
        .reg_dst(reg_dst), .wb_sel(wb_sel), .dmem_re(dmem_re), .dmem_we(dmem_we),
        .mdu_start(mdu_start), .mdu_mode(mdu_mode), .stall(stall), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign obs = {imem_req, pc_we, ir_we, pc_src, alu_op, alu_srcb, ext_op, grf_we,
                  reg_dst, wb_sel, dmem_re, dmem_we, mdu_start, mdu_mode, stall, illegal};

    task automatic chk(input string tag, input out_t got, input out_t want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, want);
        end
    endtask

    function automatic out_t f_fetch(input logic r);
        out_t o = '0;
        o.imem_req = 1'b1; o.pc_we = r; o.ir_we = r;
        return o;
    endfunction
    function automatic out_t f_alu(input logic [2:0] a, input logic sb, input logic [1:0] e,
                                   input logic [1:0] rd);
        out_t o = '0;
        o.alu_op = a; o.alu_srcb = sb; o.ext_op = e; o.reg_dst = rd;
        return o;
    endfunction
    function automatic out_t f_wb(input logic [1:0] rd, input logic [2:0] ws);
        out_t o = '0;
        o.grf_we = 1'b1; o.reg_dst = rd; o.wb_sel = ws;
        return o;
    endfunction
    function automatic out_t f_mrd(input logic r);
        out_t o = '0;
        o.dmem_re = 1'b1; o.grf_we = r; o.wb_sel = 3'b001;
        return o;
    endfunction
    function automatic out_t f_mwr();
        out_t o = '0;
        o.dmem_we = 1'b1;
        return o;
    endfunction
    function automatic out_t f_br(input logic z);
        out_t o = '0;
        o.alu_op = 3'b001; o.pc_src = 2'b01; o.pc_we = z;
        return o;
    endfunction
    function automatic out_t f_jmp(input logic [1:0] ps, input logic link);
        out_t o = '0;
        o.pc_we = 1'b1; o.pc_src = ps;
        if (link) begin o.grf_we = 1'b1; o.reg_dst = 2'b10; o.wb_sel = 3'b010; end
        return o;
    endfunction
    function automatic out_t f_flag(input int which);
        out_t o = '0;
        case (which)
            1: o.illegal = 1'b1;
            2: o.stall = 1'b1;
            3: o.mdu_start = 1'b1;
            4: begin o.mdu_start = 1'b1; o.mdu_mode = 1'b1; end
            default: ;
        endcase
        return o;
    endfunction

    // One cycle: drive inputs, queue the expectation, compare at the falling edge.
    task automatic step(input logic [5:0] o, input logic [5:0] f, input logic z, input logic ir,
                        input logic dr, input out_t e, input string tag);
        op = o; func = f; zero = z; imem_ready = ir; dmem_ready = dr;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        chk(tag_q.pop_front(), obs, exp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic fd(input logic [5:0] o, input logic [5:0] f, input string tag);
        step(o, f, 1'b0, 1'b1, 1'b1, f_fetch(1'b1), {tag, ".F"});
        step(o, f, 1'b0, 1'b1, 1'b1, '0, {tag, ".D"});
    endtask

    task automatic fd_ill(input logic [5:0] o, input logic [5:0] f, input string tag);
        step(o, f, 1'b0, 1'b1, 1'b1, f_fetch(1'b1), {tag, ".F"});
        step(o, f, 1'b0, 1'b1, 1'b1, f_flag(1), {tag, ".D"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        step(OP_R, FN_ADD, 1'b0, 1'b0, 1'b0, f_fetch(1'b0), "rst.idle");
        step(OP_R, FN_ADD, 1'b0, 1'b1, 1'b0, f_fetch(1'b1), "rst.rdy");
        rst_n = 1'b1;

        fd(OP_R, FN_ADD, "add");
        step(OP_R, FN_ADD, 1'b0, 1'b1, 1'b1, f_alu(3'b000, 1'b0, 2'b00, 2'b01), "add.X");
        step(OP_R, FN_ADD, 1'b0, 1'b1, 1'b1, f_wb(2'b01, 3'b000), "add.W");
        fd(OP_R, FN_SUB, "sub");
        step(OP_R, FN_SUB, 1'b0, 1'b1, 1'b1, f_alu(3'b001, 1'b0, 2'b00, 2'b01), "sub.X");
        step(OP_R, FN_SUB, 1'b0, 1'b1, 1'b1, f_wb(2'b01, 3'b000), "sub.W");
        fd(OP_ORI, 6'h15, "ori");
        step(OP_ORI, 6'h15, 1'b0, 1'b1, 1'b1, f_alu(3'b010, 1'b1, 2'b00, 2'b00), "ori.X");
        step(OP_ORI, 6'h15, 1'b0, 1'b1, 1'b1, f_wb(2'b00, 3'b000), "ori.W");
        fd(OP_LUI, 6'h2a, "lui");
        step(OP_LUI, 6'h2a, 1'b0, 1'b1, 1'b1, f_alu(3'b011, 1'b1, 2'b11, 2'b00), "lui.X");
        step(OP_LUI, 6'h2a, 1'b0, 1'b1, 1'b1, f_wb(2'b00, 3'b000), "lui.W");

        for (int i = 0; i < 2; i++)
            step(OP_BEQ, 6'h0, 1'b0, 1'b0, 1'b1, f_fetch(1'b0), "fetch.wait");
        fd(OP_BEQ, 6'h0, "beq0");
        step(OP_BEQ, 6'h0, 1'b0, 1'b1, 1'b1, f_br(1'b0), "beq0.B");
        fd(OP_BEQ, 6'h0, "beq1");
        step(OP_BEQ, 6'h0, 1'b1, 1'b1, 1'b1, f_br(1'b1), "beq1.B");
        fd(OP_J, 6'h3, "j");
        step(OP_J, 6'h3, 1'b0, 1'b1, 1'b1, f_jmp(2'b10, 1'b0), "j.J");
        fd(OP_JAL, 6'h0, "jal");
        step(OP_JAL, 6'h0, 1'b0, 1'b1, 1'b1, f_jmp(2'b10, 1'b1), "jal.J");
        fd(OP_R, FN_JR, "jr");
        step(OP_R, FN_JR, 1'b0, 1'b1, 1'b1, f_jmp(2'b11, 1'b0), "jr.J");

        fd(OP_LW, 6'h4, "lw");
        step(OP_LW, 6'h4, 1'b0, 1'b1, 1'b0, f_alu(3'b000, 1'b1, 2'b01, 2'b00), "lw.A");
        for (int i = 0; i < 3; i++)
            step(OP_LW, 6'h4, 1'b0, 1'b1, 1'b0, f_mrd(1'b0), "lw.wait");
        step(OP_LW, 6'h4, 1'b0, 1'b1, 1'b1, f_mrd(1'b1), "lw.R");
        fd(OP_SW, 6'h8, "sw");
        step(OP_SW, 6'h8, 1'b0, 1'b1, 1'b0, f_alu(3'b000, 1'b1, 2'b01, 2'b00), "sw.A");
        step(OP_SW, 6'h8, 1'b0, 1'b1, 1'b0, f_mwr(), "sw.wait");
        step(OP_SW, 6'h8, 1'b0, 1'b1, 1'b1, f_mwr(), "sw.W");

        fd_ill(OP_BAD, 6'h0, "ill");
        fd_ill(OP_R, 6'b111111, "illfn");

        // reset while a load is waiting on dmem_ready
        fd(OP_LW, 6'h4, "lwr");
        step(OP_LW, 6'h4, 1'b0, 1'b1, 1'b0, f_alu(3'b000, 1'b1, 2'b01, 2'b00), "lwr.A");
        step(OP_LW, 6'h4, 1'b0, 1'b1, 1'b0, f_mrd(1'b0), "lwr.wait");
        rst_n = 1'b0;
        step(OP_LW, 6'h4, 1'b0, 1'b0, 1'b0, f_fetch(1'b0), "rst.mid");
        rst_n = 1'b1;
        step(OP_LW, 6'h4, 1'b0, 1'b0, 1'b0, f_fetch(1'b0), "rst.after");

`ifdef MC_CTRL_MDU_EN
        fd_ill(OP_BAD, 6'h0, "pre");
        step(OP_R, FN_MULT, 1'b0, 1'b1, 1'b1, f_fetch(1'b1), "mult.F");
        step(OP_R, FN_MULT, 1'b0, 1'b1, 1'b1, f_flag(3), "mult.D");
        step(OP_R, FN_MFLO, 1'b0, 1'b1, 1'b1, f_fetch(1'b1), "mflo.F");
        for (int i = 0; i < MUL_LAT - 2; i++)
            step(OP_R, FN_MFLO, 1'b0, 1'b1, 1'b1, f_flag(2), "mflo.stall");
        step(OP_R, FN_MFLO, 1'b0, 1'b1, 1'b1, '0, "mflo.D");
        step(OP_R, FN_MFLO, 1'b0, 1'b1, 1'b1, f_wb(2'b01, 3'b100), "mflo.W");

        step(OP_R, FN_DIV, 1'b0, 1'b1, 1'b1, f_fetch(1'b1), "div.F");
        step(OP_R, FN_DIV, 1'b0, 1'b1, 1'b1, f_flag(4), "div.D");
        step(OP_R, FN_MFHI, 1'b0, 1'b1, 1'b1, f_fetch(1'b1), "mfhi.F");
        for (int i = 0; i < DIV_LAT - 2; i++)
            step(OP_R, FN_MFHI, 1'b0, 1'b1, 1'b1, f_flag(2), "mfhi.stall");
        step(OP_R, FN_MFHI, 1'b0, 1'b1, 1'b1, '0, "mfhi.D");
        step(OP_R, FN_MFHI, 1'b0, 1'b1, 1'b1, f_wb(2'b01, 3'b011), "mfhi.W");

        // reset must clear the busy counter
        step(OP_R, FN_MULT, 1'b0, 1'b1, 1'b1, f_fetch(1'b1), "mult2.F");
        step(OP_R, FN_MULT, 1'b0, 1'b1, 1'b1, f_flag(3), "mult2.D");
        rst_n = 1'b0;
        step(OP_R, FN_MFLO, 1'b0, 1'b0, 1'b1, f_fetch(1'b0), "rst.cnt");
        rst_n = 1'b1;
        fd(OP_R, FN_MFLO, "mflo2");
        step(OP_R, FN_MFLO, 1'b0, 1'b1, 1'b1, f_wb(2'b01, 3'b100), "mflo2.W");
`else
        fd_ill(OP_R, FN_MULT, "mult");
        fd_ill(OP_R, FN_DIV, "div");
        fd_ill(OP_R, FN_MFHI, "mfhi");
        fd_ill(OP_R, FN_MFLO, "mflo");
`endif
        step(OP_R, FN_ADD, 1'b0, 1'b1, 1'b1, f_fetch(1'b1), "end.F");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
